// File: rtl/inst_axi_rd_bridge_pkg.sv
// ----------------------------------------------------------------------------
// inst_axi_rd_bridge_pkg
//   Shared AXI / SRAM-like defines for the instruction-side read bridge.
//   Holds the bridge FSM state encoding, the fixed AXI burst constants, and a
//   small helper that converts an SRAM-like transfer size into an AXI ARSIZE.
// ----------------------------------------------------------------------------
package inst_axi_rd_bridge_pkg;

    // Bridge FSM states. Two bits, one state per phase of a single
    // outstanding transaction.
    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,  // waiting for an SRAM-like read request
        ST_AR   = 2'b01,  // AXI read-address handshake in progress
        ST_R    = 2'b10,  // waiting for the single AXI read-data beat
        ST_DONE = 2'b11   // one-cycle data_ok pulse back to the initiator
    } state_t;

    // Every request becomes exactly one AXI beat, so ARLEN is always zero.
    localparam logic [7:0] ARLEN_SINGLE = 8'd0;

    // SRAM-like size encoding for a full 32-bit word.
    localparam logic [1:0] SIZE_WORD    = 2'b10;

    // SRAM-like sizes 0/1/2 (byte/half/word) line up with AXI ARSIZE 0/1/2,
    // so the conversion is just a zero-extension to three bits.
    function automatic logic [2:0] to_arsize(input logic [1:0] sram_size);
        return {1'b0, sram_size};
    endfunction

endpackage : inst_axi_rd_bridge_pkg

// File: rtl/inst_axi_rd_bridge.sv
// ----------------------------------------------------------------------------
// inst_axi_rd_bridge
//   Instruction-side responder for the SRAM-like fetch interface. Each accepted
//   single-beat read request is turned into one AXI read burst of length one,
//   and the returned beat is handed back with a one-cycle inst_data_ok pulse.
//   Only one transaction is ever outstanding.
//
// Ports
//   clk, rst          core clock; asynchronous active-high reset
//   inst_req          SRAM-like request valid
//   inst_wr           SRAM-like write flag (writes are never accepted)
//   inst_size         transfer size: 0=byte, 1=half, 2=word
//   inst_addr         request address
//   inst_wdata        write data, ignored by this read-only bridge
//   inst_addr_ok      request accepted this cycle
//   inst_data_ok      read data valid this cycle (single-cycle pulse)
//   inst_rdata        last captured read data
//   araddr/arlen/arsize/arvalid/arready   AXI read-address channel
//   rdata/rvalid/rready                   AXI read-data channel
// ----------------------------------------------------------------------------
module inst_axi_rd_bridge
    import inst_axi_rd_bridge_pkg::*;
#(
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rst,

    input  logic              inst_req,
    input  logic              inst_wr,
    input  logic [1:0]        inst_size,
    input  logic [ADDR_W-1:0] inst_addr,
    input  logic [31:0]       inst_wdata,
    output logic              inst_addr_ok,
    output logic              inst_data_ok,
    output logic [31:0]       inst_rdata,

    output logic [ADDR_W-1:0] araddr,
    output logic [7:0]        arlen,
    output logic [2:0]        arsize,
    output logic              arvalid,
    input  logic              arready,

    input  logic [31:0]       rdata,
    input  logic              rvalid,
    output logic              rready
);

    state_t            state;
    state_t            state_next;

    logic [ADDR_W-1:0] addr_q;
    logic [1:0]        size_q;
    logic [31:0]       rdata_q;

    logic              accept;
    logic              capture;

    // The write-data bus exists only to match the SRAM-like interface shape;
    // folding it into a dummy signal keeps it visibly intentional.
    logic              unused_wdata;
    assign unused_wdata = ^inst_wdata;

    // A request is taken only while idle and only when it is a read. A write
    // request is left hanging on purpose: the initiator stalls, which makes the
    // illegal access obvious at system level instead of silently dropping it.
    assign accept  = (state == ST_IDLE) && inst_req && !inst_wr;

    // The read beat is consumed only while waiting for it, so a stray rvalid
    // in any other state is neither acknowledged nor captured.
    assign capture = (state == ST_R) && rvalid;

    // State register. Reset drops the bridge straight back to idle, which also
    // deasserts arvalid/rready in the same cycle because they decode from state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic. AR and R wait indefinitely on their handshakes; there
    // is no timeout because the interconnect is trusted to respond eventually.
    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE: begin
                if (accept) begin
                    state_next = ST_AR;
                end
            end
            ST_AR: begin
                if (arready) begin
                    state_next = ST_R;
                end
            end
            ST_R: begin
                if (rvalid) begin
                    state_next = ST_DONE;
                end
            end
            ST_DONE: begin
                state_next = ST_IDLE;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    // Output decode. addr_ok is only possible in IDLE and data_ok only in DONE,
    // so the two handshakes can never coincide.
    always_comb begin
        inst_addr_ok = 1'b0;
        inst_data_ok = 1'b0;
        arvalid      = 1'b0;
        rready       = 1'b0;
        case (state)
            ST_IDLE: inst_addr_ok = accept;
            ST_AR:   arvalid      = 1'b1;
            ST_R:    rready       = 1'b1;
            ST_DONE: inst_data_ok = 1'b1;
            default: begin
                inst_addr_ok = 1'b0;
            end
        endcase
    end

    // Request holding registers. Address and size are frozen at acceptance so
    // that araddr/arsize stay stable for the whole AR handshake even if the
    // initiator changes its bus afterwards.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            addr_q <= '0;
            size_q <= 2'b00;
        end else if (accept) begin
            addr_q <= inst_addr;
            size_q <= inst_size;
        end
    end

    // Read-data holding register. It only updates on the consumed beat, so the
    // last fetched word stays visible between transactions.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rdata_q <= 32'h0000_0000;
        end else if (capture) begin
            rdata_q <= rdata;
        end
    end

    assign araddr     = addr_q;
    assign arsize     = to_arsize(size_q);
    assign arlen      = ARLEN_SINGLE;
    assign inst_rdata = rdata_q;

    // Protocol guards: the two SRAM-like handshakes are mutually exclusive, and
    // once arvalid is raised it must hold, with a stable address, until taken.
    a_no_addr_data_overlap: assert property (
        @(posedge clk) disable iff (rst) !(inst_addr_ok && inst_data_ok)
    );

    a_arvalid_held: assert property (
        @(posedge clk) disable iff (rst)
        (arvalid && !arready) |=> (arvalid && $stable(araddr) && $stable(arsize))
    );

endmodule : inst_axi_rd_bridge
